oled_spi_tx: RTL and testbench

OLED_SPI_TX -- requirements
Module: oled_spi_tx

---
 rtl/oled_spi_tx.sv | 152 +++++++++++++++
 tb/tb_oled_spi_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_tx.sv
// Write-buffered serialiser for an SPI OLED panel: MSB-first bytes, sclk idles high, dc held per byte.
// Define OLED_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module oled_spi_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       cpu_resetn,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic       wr_dc,
  output logic       busy,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_dc
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 255 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("oled_spi_tx: illegal CLK_DIV or FIFO_DEPTH");
  end

  state_e     state_q;
  logic [7:0] div_q;
  logic [2:0] idx_q;
  logic [6:0] shreg_q;
  logic       sclk_q;
  logic       sdin_q;
  logic       dc_q;

  logic       push;
  logic       pop;
  logic       buf_empty;
  logic [8:0] head;

  assign push = wr_valid & wr_ready;
  assign pop  = (state_q == StIdle) & ~buf_empty;

`ifdef OLED_TX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_dc, wr_data};
  end

  // Count never exceeds FIFO_DEPTH (a power of two), so its top bit marks full.
  assign wr_ready  = ~count_q[PtrW];
  assign buf_empty = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
`else
  logic       hold_valid_q;
  logic [8:0] hold_q;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_q       <= {wr_dc, wr_data};
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign wr_ready  = ~hold_valid_q;
  assign buf_empty = ~hold_valid_q;
  assign head      = hold_q;
`endif

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= StIdle;
      div_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b1;
      sdin_q  <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!buf_empty) begin
            state_q <= StShift;
            sclk_q  <= 1'b0;
            sdin_q  <= head[7];
            dc_q    <= head[8];
            shreg_q <= head[6:0];
            idx_q   <= 3'd7;
            div_q   <= '0;
          end
        end
        StShift: begin
          if (div_q == DivLast) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (idx_q != 3'd0) begin
              // Next bit goes out on the same edge that drops sclk.
              idx_q   <= idx_q - 3'd1;
              sdin_q  <= shreg_q[6];
              shreg_q <= {shreg_q[5:0], 1'b0};
              sclk_q  <= 1'b0;
            end else begin
              state_q <= StGap;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        StGap: begin
          if (div_q == DivLast) state_q <= StIdle;
          else                  div_q   <= div_q + 8'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oled_sclk = sclk_q;
  assign oled_sdin = sdin_q;
  assign oled_dc   = dc_q;
  assign busy      = (state_q != StIdle) | ~buf_empty;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx: one instance at CLK_DIV=4, one at CLK_DIV=1, serial monitors decode bytes.
module tb_oled_spi_tx;

`ifdef OLED_TX_FIFO_EN
  localparam int Acc1 = 1;    // second write accepted on the very next edge
  localparam int Acc4 = 4;
  localparam bit FifoOn = 1'b1;
`else
  localparam int Acc1 = 2;    // holding register frees one edge after the pop
  localparam int Acc4 = 209;
  localparam bit FifoOn = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  int         cyc    = 0;

  logic       wr_valid_a = 1'b0, wr_dc_a = 1'b0, wr_ready_a, busy_a, sclk_a, sdin_a, dc_a;
  logic [7:0] wr_data_a  = 8'h00;
  logic       wr_valid_b = 1'b0, wr_dc_b = 1'b0, wr_ready_b, busy_b, sclk_b, sdin_b, dc_b;
  logic [7:0] wr_data_b  = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  oled_spi_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut_a (
    .sysclk(sysclk), .cpu_resetn(rst_n), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .wr_data(wr_data_a), .wr_dc(wr_dc_a), .busy(busy_a), .oled_sclk(sclk_a),
    .oled_sdin(sdin_a), .oled_dc(dc_a)
  );

  oled_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut_b (
    .sysclk(sysclk), .cpu_resetn(rst_n), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_data(wr_data_b), .wr_dc(wr_dc_b), .busy(busy_b), .oled_sclk(sclk_b),
    .oled_sdin(sdin_b), .oled_dc(dc_b)
  );

  // Serial monitor A: bytes as {dc, data}, cycle of every sclk rise and of each byte's first rise.
  int         bitcnt_a = 0;
  logic [6:0] sh_a     = '0;
  logic       dc0_a    = 1'b0;
  int         dc_err   = 0;
  int         rx_a[$];
  int         rise_a[$];
  int         start_a[$];

  always @(posedge sclk_a or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_a <= 0;
    end else begin
      rise_a.push_back(cyc);
      if (bitcnt_a == 0) begin
        start_a.push_back(cyc);
        dc0_a <= dc_a;
      end else if (dc_a != dc0_a) begin
        dc_err <= dc_err + 1;
      end
      sh_a <= {sh_a[5:0], sdin_a};
      if (bitcnt_a == 7) begin
        rx_a.push_back(int'({dc0_a, sh_a, sdin_a}));
        bitcnt_a <= 0;
      end else begin
        bitcnt_a <= bitcnt_a + 1;
      end
    end
  end

  int         bitcnt_b = 0;
  logic [6:0] sh_b     = '0;
  int         rx_b[$];
  int         rise_b[$];

  always @(posedge sclk_b or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_b <= 0;
    end else begin
      rise_b.push_back(cyc);
      sh_b <= {sh_b[5:0], sdin_b};
      if (bitcnt_b == 7) begin
        rx_b.push_back(int'({sh_b, sdin_b}));
        bitcnt_b <= 0;
      end else begin
        bitcnt_b <= bitcnt_b + 1;
      end
    end
  end

  // sdin/dc must never move while sclk stays high between two samples.
  int   viol   = 0;
  logic p_sclk = 1'b1, p_sdin = 1'b0, p_dc = 1'b0, p_rst = 1'b0;

  always @(negedge sysclk) begin
    if (rst_n && p_rst && p_sclk && sclk_a && (sdin_a != p_sdin || dc_a != p_dc))
      viol <= viol + 1;
    p_sclk <= sclk_a;
    p_sdin <= sdin_a;
    p_dc   <= dc_a;
    p_rst  <= rst_n;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic push_a(input string tag, input logic [7:0] d, input logic dcv, output int acc);
    acc = -1;
    wr_valid_a = 1'b1;
    wr_data_a  = d;
    wr_dc_a    = dcv;
    for (int n = 0; n < 1000; n++) begin
      logic rdy;
      rdy = wr_ready_a;
      @(posedge sysclk); #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    wr_valid_a = 1'b0;
    check_eq(tag, (acc >= 0), 1);
  endtask

  task automatic wait_idle_a(input string tag);
    for (int n = 0; n < 3000 && busy_a; n++) begin
      @(posedge sysclk); #1;
    end
    check_eq(tag, busy_a, 0);
  endtask

  initial begin
    int acc[5];
    int t0, n, rb, sb, rise_base;

    repeat (3) @(posedge sysclk);
    #1;
    check_eq("rst_sclk", sclk_a, 1);
    check_eq("rst_sdin", sdin_a, 0);
    check_eq("rst_dc", dc_a, 0);
    check_eq("rst_ready", wr_ready_a, 1);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_ready_b", wr_ready_b, 1);

    // Command byte 0xA5; the write lands on the first edge after release.
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    t0 = cyc;
    push_a("a_acc", 8'hA5, 1'b0, acc[0]);
    check_eq("first_write_edge", acc[0] - t0, 1);
    n = 0;
    while (busy_a && n < 500) begin
      @(posedge sysclk); #1;
      n++;
    end
    check_eq("a_busy_cycles", n, 69);
    check_eq("a_rx_count", rx_a.size(), 1);
    check_eq("a_rx_byte", q_at(rx_a, 0), 32'h0A5);
    check_eq("a_sclk_period", q_at(rise_a, 1) - q_at(rise_a, 0), 8);
    check_eq("a_hold_sdin", sdin_a, 1);
    check_eq("a_hold_dc", dc_a, 0);
    check_eq("a_idle_sclk", sclk_a, 1);

    // Back-to-back fill 0x01..0x05 as data bytes.
    rb = rx_a.size();
    sb = start_a.size();
    for (int i = 0; i < 5; i++) push_a("b_acc", 8'(i + 1), 1'b1, acc[i]);
    check_eq("b_ready_after_fill", wr_ready_a, 0);
    check_eq("b_acc2_offset", acc[1] - acc[0], Acc1);
    check_eq("b_acc5_offset", acc[4] - acc[0], Acc4);
    wait_idle_a("b_idle");
    for (int i = 0; i < 5; i++) check_eq("b_rx_byte", q_at(rx_a, rb + i), 32'h100 + i + 1);
    for (int i = 1; i < 5; i++)
      check_eq("b_start_gap", q_at(start_a, sb + i) - q_at(start_a, sb + i - 1), 69);

    // Data 0xFF followed by command 0x00.
    rb = rx_a.size();
    push_a("c_acc", 8'hFF, 1'b1, acc[0]);
    push_a("c_acc", 8'h00, 1'b0, acc[1]);
    wait_idle_a("c_idle");
    check_eq("c_rx_ff", q_at(rx_a, rb), 32'h1FF);
    check_eq("c_rx_00", q_at(rx_a, rb + 1), 32'h000);

    // Reset during the fourth bit of 0x3C while further entries wait.
    rb = rx_a.size();
    rise_base = rise_a.size();
    push_a("d_acc", 8'h3C, 1'b1, acc[0]);
    push_a("d_acc", 8'h11, 1'b1, acc[1]);
    if (FifoOn) push_a("d_acc", 8'h22, 1'b1, acc[2]);
    for (int k = 0; k < 2000 && rise_a.size() < rise_base + 3; k++) begin
      @(posedge sysclk); #1;
    end
    check_eq("d_three_bits", rise_a.size(), rise_base + 3);
    repeat (5) @(posedge sysclk);
    #1;
    check_eq("d_low_phase_sdin", {sclk_a, sdin_a}, 2'b01);
    rst_n = 1'b0;
    #1;
    check_eq("d_rst_sclk", sclk_a, 1);
    check_eq("d_rst_sdin", sdin_a, 0);
    check_eq("d_rst_dc", dc_a, 0);
    check_eq("d_rst_busy", busy_a, 0);
    check_eq("d_rst_ready", wr_ready_a, 1);
    repeat (3) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    repeat (200) @(posedge sysclk);
    #1;
    check_eq("d_no_rises", rise_a.size(), rise_base + 3);
    check_eq("d_no_bytes", rx_a.size(), rb);
    check_eq("d_idle_busy", busy_a, 0);
    push_a("d_acc", 8'h5A, 1'b1, acc[0]);
    wait_idle_a("d_idle");
    check_eq("d_recover_byte", q_at(rx_a, rb), 32'h15A);

    // Minimum divider on the second instance.
    wr_valid_b = 1'b1;
    wr_data_b  = 8'h80;
    wr_dc_b    = 1'b0;
    check_eq("f_ready", wr_ready_b, 1);
    @(posedge sysclk); #1;
    wr_valid_b = 1'b0;
    n = 0;
    while (busy_b && n < 200) begin
      @(posedge sysclk); #1;
      n++;
    end
    check_eq("f_busy_cycles", n, 18);
    check_eq("f_rx_byte", q_at(rx_b, 0), 32'h80);
    check_eq("f_sclk_period", q_at(rise_b, 1) - q_at(rise_b, 0), 2);
    check_eq("f_hold_sdin", sdin_b, 0);
    check_eq("f_dc", dc_b, 0);

    check_eq("dc_stable_in_byte", dc_err, 0);
    check_eq("sdin_dc_while_sclk_high", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
